// File: rtl/bram_delay_line.sv
// Sample-counted programmable delay line built on a synchronous 1R1W block RAM.
// A registered-read bypass hides the RAM latency so the delay holds across stalls and at D=1.

module bram_1r1w #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Read-first: a same-edge write to rd_addr returns the previous contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

module bram_delay_line #(
    parameter int WIDTH       = 8,
    parameter int MAX_DELAY   = 16,
    parameter int RESET_DELAY = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic [WIDTH-1:0]               d,
    input  logic                           flush,
    input  logic                           cfg_wr,
    input  logic [$clog2(MAX_DELAY+1)-1:0] cfg_delay,
    output logic [WIDTH-1:0]               q,
    output logic                           q_valid,
    output logic [$clog2(MAX_DELAY+1)-1:0] cur_delay
);
    localparam int CW = $clog2(MAX_DELAY + 1);
    localparam int AW = $clog2(MAX_DELAY);

    function automatic logic [CW-1:0] clamp_delay(input logic [CW-1:0] v);
        if (v == '0) return CW'(1);
        if (v > CW'(MAX_DELAY)) return CW'(MAX_DELAY);
        return v;
    endfunction

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p, input logic [CW-1:0] dly);
        if (CW'(p) == dly - CW'(1)) return '0;
        return p + AW'(1);
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt, input logic [CW-1:0] lim);
        if (cnt >= lim) return lim;
        return cnt + CW'(1);
    endfunction

    logic [AW-1:0]    wp, wp_next;
    logic [CW-1:0]    fill;
    logic             accept;
    logic [WIDTH-1:0] rd_data_p1;
    logic             byp_vld_p1;
    logic [WIDTH-1:0] byp_data_p1;
    logic [WIDTH-1:0] rd_val;

    // The RAM is always read at the pointer that will be current after this edge,
    // so its output already holds the oldest stored sample when the next accept comes.
    always_comb begin
        accept = en & ~cfg_wr & ~flush;
        if (reset || cfg_wr || flush) wp_next = '0;
        else if (en)                   wp_next = wrap_inc(wp, cur_delay);
        else                           wp_next = wp;
    end

    bram_1r1w #(.WIDTH(WIDTH), .DEPTH(MAX_DELAY), .AW(AW)) u_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wp),
        .wr_data (d),
        .rd_addr (wp_next),
        .rd_data (rd_data_p1)
    );

    assign rd_val = byp_vld_p1 ? byp_data_p1 : rd_data_p1;

    // ---- stage p1: bypass capture for a write landing on the address being read
    always_ff @(posedge clk) begin
        byp_data_p1 <= d;
    end

    // ---- output stage: pointers, fill count and delayed sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_delay  <= CW'(RESET_DELAY);
            wp         <= '0;
            fill       <= '0;
            q          <= '0;
            q_valid    <= 1'b0;
            byp_vld_p1 <= 1'b0;
        end else begin
            byp_vld_p1 <= accept && (wp == wp_next);
            if (cfg_wr) begin
                cur_delay <= clamp_delay(cfg_delay);
                wp        <= '0;
                fill      <= '0;
                q         <= '0;
                q_valid   <= 1'b0;
            end else if (flush) begin
                wp      <= '0;
                fill    <= '0;
                q       <= '0;
                q_valid <= 1'b0;
            end else if (en) begin
                wp   <= wp_next;
                fill <= sat_inc(fill, cur_delay);
                if (fill == cur_delay) begin
                    q       <= rd_val;
                    q_valid <= 1'b1;
                end else begin
                    q       <= '0;
                    q_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_bram_delay_line.sv
// Randomised bench for bram_delay_line against a queue-based model of the
// sample-counted delay, plus directed stall, reconfigure, flush and reset scenarios.

module tb_bram_delay_line;
    localparam int WIDTH       = 8;
    localparam int MAX_DELAY   = 16;
    localparam int RESET_DELAY = 4;
    localparam int CW          = $clog2(MAX_DELAY + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic             flush = 1'b0;
    logic             cfg_wr = 1'b0;
    logic [CW-1:0]    cfg_delay = '0;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [CW-1:0]    cur_delay;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int               m_delay;
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] exp_q;
    logic             exp_v;
    int               seen99;

    bram_delay_line #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .RESET_DELAY(RESET_DELAY)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .d         (d),
        .flush     (flush),
        .cfg_wr    (cfg_wr),
        .cfg_delay (cfg_delay),
        .q         (q),
        .q_valid   (q_valid),
        .cur_delay (cur_delay)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_clamp(input int v);
        if (v == 0) return 1;
        if (v > MAX_DELAY) return MAX_DELAY;
        return v;
    endfunction

    task automatic model_clear();
        hist.delete();
        exp_q = '0;
        exp_v = 1'b0;
    endtask

    task automatic model_reset();
        m_delay = RESET_DELAY;
        model_clear();
    endtask

    // Apply one edge of the reference behaviour using the inputs present at that edge.
    task automatic model_edge();
        if (cfg_wr) begin
            m_delay = model_clamp(int'(cfg_delay));
            model_clear();
        end else if (flush) begin
            model_clear();
        end else if (en) begin
            hist.push_back(d);
            if (hist.size() > m_delay) begin
                exp_q = hist[hist.size() - 1 - m_delay];
                exp_v = 1'b1;
            end else begin
                exp_q = '0;
                exp_v = 1'b0;
            end
            while (hist.size() > m_delay + 1) void'(hist.pop_front());
        end
    endtask

    // Drive one cycle from a negedge, then compare at the following negedge.
    task automatic cycle(input logic e, input logic [WIDTH-1:0] dv, input logic fl,
                         input logic cw, input logic [CW-1:0] cd, input string tag);
        en = e; d = dv; flush = fl; cfg_wr = cw; cfg_delay = cd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check({tag, "_q"}, 32'(q), 32'(exp_q));
        check({tag, "_vld"}, 32'(q_valid), 32'(exp_v));
        check({tag, "_dly"}, 32'(cur_delay), 32'(m_delay));
        if (q_valid && q == 8'd99) seen99++;
    endtask

    initial begin
        seen99 = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_q", 32'(q), 32'd0);
        check("rst_vld", 32'(q_valid), 32'd0);
        check("rst_dly", 32'(cur_delay), 32'(RESET_DELAY));
        reset = 1'b0;

        // Continuous stream after reset: valid on the 5th edge with q=1, then q=d-4.
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, WIDTH'(i), 1'b0, 1'b0, '0, "stream");
            if (i == 5) check("first_valid_q", 32'(q), 32'd1);
            if (i == 4) check("pre_valid", 32'(q_valid), 32'd0);
        end

        // Alternating stalls at D=4.
        cycle(1'b0, '0, 1'b1, 1'b0, '0, "stall_flush");
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, WIDTH'(i), 1'b0, 1'b0, '0, "stall_on");
            cycle(1'b0, 8'hEE, 1'b0, 1'b0, '0, "stall_off");
        end

        // One-sample delay.
        cycle(1'b1, 8'd55, 1'b0, 1'b1, CW'(1), "cfg1");
        cycle(1'b1, 8'd10, 1'b0, 1'b0, '0, "d1_a");
        check("d1_a_vld", 32'(q_valid), 32'd0);
        cycle(1'b1, 8'd11, 1'b0, 1'b0, '0, "d1_b");
        check("d1_b_q", 32'(q), 32'd10);
        cycle(1'b1, 8'd12, 1'b0, 1'b0, '0, "d1_c");
        check("d1_c_q", 32'(q), 32'd11);
        cycle(1'b0, 8'd13, 1'b0, 1'b0, '0, "d1_hold");
        cycle(1'b1, 8'd14, 1'b0, 1'b0, '0, "d1_after_hold");

        // Clamping at both ends and the maximum delay in steady state.
        cycle(1'b0, '0, 1'b0, 1'b1, CW'(0), "cfg0");
        check("cfg0_dly", 32'(cur_delay), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1, CW'(MAX_DELAY + 5), "cfgbig");
        check("cfgbig_dly", 32'(cur_delay), 32'(MAX_DELAY));
        for (int i = 1; i <= 3 * MAX_DELAY; i++) cycle(1'b1, WIDTH'(i + 100), 1'b0, 1'b0, '0, "dmax");
        check("dmax_q", 32'(q), 32'(3 * MAX_DELAY + 100 - MAX_DELAY));

        // Flush mid-stream at D=4 with a sample of 99 that must be discarded.
        cycle(1'b0, '0, 1'b0, 1'b1, CW'(4), "cfg4");
        for (int i = 1; i <= 10; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0, '0, "pre_flush");
        seen99 = 0;
        cycle(1'b1, 8'd99, 1'b1, 1'b0, '0, "flush99");
        check("flush_q", 32'(q), 32'd0);
        check("flush_vld", 32'(q_valid), 32'd0);
        for (int i = 1; i <= 5; i++) cycle(1'b1, WIDTH'(200 + i), 1'b0, 1'b0, '0, "post_flush");
        check("post_flush_q", 32'(q), 32'd201);
        check("post_flush_vld", 32'(q_valid), 32'd1);
        check("no99", 32'(seen99), 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            automatic int r = int'($urandom_range(99, 0));
            automatic logic fl = (r < 2);
            automatic logic cw = (r >= 2 && r < 4);
            automatic logic e = ($urandom_range(9, 0) < 7);
            cycle(e, WIDTH'($urandom), fl, cw, CW'($urandom_range(MAX_DELAY + 5, 0)), "rand");
        end

        // Asynchronous reset between edges mid-stream.
        cycle(1'b0, '0, 1'b0, 1'b1, CW'(7), "cfg7");
        for (int i = 1; i <= 12; i++) cycle(1'b1, WIDTH'(i + 30), 1'b0, 1'b0, '0, "pre_rst");
        #2 reset = 1'b1;
        #1;
        check("arst_q", 32'(q), 32'd0);
        check("arst_vld", 32'(q_valid), 32'd0);
        check("arst_dly", 32'(cur_delay), 32'(RESET_DELAY));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) cycle(1'b1, WIDTH'(i + 60), 1'b0, 1'b0, '0, "post_rst");
        check("post_rst_q", 32'(q), 32'(72 - RESET_DELAY));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
